// File: rtl/vend_dispense_sequencer.sv
// vend_dispense_sequencer: vending transaction controller -- accumulates coin credit,
// checks a selection against the price table, runs the dispense handshake, then returns
// change one coin at a time.
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   coin_valid, coin_val    coin pulse and code (00=5c, 01=10c, 10=25c, 11=invalid)
//   coin_rej                pulse, coin returned unaccepted
//   sel_valid, sel          product selection pulse and index
//   cancel                  refund request pulse
//   disp_req/disp_sel/disp_ack   dispense handshake
//   chg_req/chg_coin/chg_ack     change handshake (chg_coin 0=5c, 1=10c)
//   credit                  current credit in 5c units
//   busy, err_price, fault  status: not idle, selection refused, dispense timeout
// Optional feature: define VEND_TIMEOUT_EN to add the dispense-ack timeout (TIMEOUT
// parameter, counter and fault pulse); otherwise DISPENSE waits forever and fault is 0.
module vend_dispense_sequencer #(
    parameter int CREDIT_W = 6,
    parameter int NUM_SEL  = 4,
    parameter logic [NUM_SEL*CREDIT_W-1:0] PRICES = {6'd5, 6'd4, 6'd3, 6'd2}
`ifdef VEND_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    output logic                coin_rej,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_sel,
    input  logic                disp_ack,
    output logic                chg_req,
    output logic                chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                err_price,
    output logic                fault
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DISPENSE = 2'd1;
    localparam logic [1:0] CHANGE   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [1:0]          disp_sel_q, disp_sel_d;
    logic                disp_req_q, chg_req_q, chg_req_d, chg_coin_q;
    logic                coin_rej_q, coin_rej_d, err_price_q, err_price_d, busy_q;
    logic                timeout;

    // Products at or beyond NUM_SEL read as price 0, i.e. disabled.
    logic [CREDIT_W-1:0] price_tab [4];
    for (genvar i = 0; i < 4; i++) begin : g_price
        if (i < NUM_SEL) begin : g_on
            assign price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
        end else begin : g_off
            assign price_tab[i] = '0;
        end
    end

    logic [CREDIT_W-1:0] sel_price;
    logic [2:0]          coin_units;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    assign sel_price  = price_tab[sel];
    assign coin_units = coin_val == 2'd0 ? 3'd1 : coin_val == 2'd1 ? 3'd2 : coin_val == 2'd2 ? 3'd5 : 3'd0;
    // Extra top bit of the sum flags credit overflow.
    assign coin_sum   = {1'b0, credit_q} + {{(CREDIT_W-2){1'b0}}, coin_units};
    assign coin_ok    = state_q == IDLE && coin_units != 3'd0 && !coin_sum[CREDIT_W];

    always_comb begin
        state_d     = state_q;
        credit_d    = coin_valid && coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
        price_d     = price_q;
        disp_sel_d  = disp_sel_q;
        chg_req_d   = 1'b0;
        coin_rej_d  = coin_valid && !coin_ok;
        err_price_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Decisions use the registered credit; a same-cycle coin still lands.
                if (cancel) begin
                    state_d = credit_q != '0 ? CHANGE : IDLE;
                end else if (sel_valid) begin
                    if (sel_price != '0 && credit_q >= sel_price) begin
                        state_d    = DISPENSE;
                        disp_sel_d = sel;
                        price_d    = sel_price;
                    end else begin
                        err_price_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                // A same-cycle ack beats the timeout; a timeout keeps the full credit.
                if (disp_ack) begin
                    credit_d = credit_q - price_q;
                    state_d  = credit_q != price_q ? CHANGE : IDLE;
                end else if (timeout) begin
                    state_d = CHANGE;
                end
            end
            CHANGE: begin
                // Request drops for one cycle after each ack, then re-asserts.
                chg_req_d = !(chg_req_q && chg_ack);
                if (chg_req_q && chg_ack)
                    credit_d = credit_q - {{(CREDIT_W-2){1'b0}}, chg_coin_q, ~chg_coin_q};
                state_d = credit_d == '0 ? IDLE : CHANGE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            price_q     <= '0;
            disp_sel_q  <= 2'd0;
            disp_req_q  <= 1'b0;
            chg_req_q   <= 1'b0;
            chg_coin_q  <= 1'b0;
            coin_rej_q  <= 1'b0;
            err_price_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            price_q     <= price_d;
            disp_sel_q  <= disp_sel_d;
            disp_req_q  <= state_d == DISPENSE;
            chg_req_q   <= chg_req_d;
            // Coin choice follows the post-ack credit so it is settled before req re-rises.
            chg_coin_q  <= state_d == CHANGE && credit_d >= CREDIT_W'(2);
            coin_rej_q  <= coin_rej_d;
            err_price_q <= err_price_d;
            busy_q      <= state_d != IDLE;
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
    // cnt_q holds k-1 during the k-th cycle of DISPENSE.
    assign timeout = cnt_q == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= state_q == DISPENSE ? cnt_q + CNT_W'(1) : '0;
            fault_q <= state_q == DISPENSE && !disp_ack && timeout;
        end
    end
    assign fault = fault_q;
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    assign coin_rej  = coin_rej_q;
    assign disp_req  = disp_req_q;
    assign disp_sel  = disp_sel_q;
    assign chg_req   = chg_req_q;
    assign chg_coin  = chg_coin_q;
    assign credit    = credit_q;
    assign busy      = busy_q;
    assign err_price = err_price_q;
endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// tb_vend_dispense_sequencer: directed bench with a transaction-rule model checked every cycle.
module tb_vend_dispense_sequencer;
`ifdef VEND_TIMEOUT_EN
    localparam int TO = 255;
`endif
    logic       clk = 1'b0, reset_n = 1'b0;
    logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
    logic [1:0] coin_val = 2'd0, sel = 2'd0;
    logic       coin_rej, disp_req, chg_req, chg_coin, busy, err_price, fault;
    logic [1:0] disp_sel;
    logic [5:0] credit;

    int tests = 0, fails = 0;

    vend_dispense_sequencer #(
        .CREDIT_W(6), .NUM_SEL(4), .PRICES({6'd0, 6'd3, 6'd3, 6'd2})
`ifdef VEND_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_val(coin_val),
        .coin_rej(coin_rej), .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .disp_req(disp_req), .disp_sel(disp_sel), .disp_ack(disp_ack), .chg_req(chg_req),
        .chg_coin(chg_coin), .chg_ack(chg_ack), .credit(credit), .busy(busy),
        .err_price(err_price), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: credit in units, phase 0=idle 1=dispensing 2=returning change.
    int units [4] = '{1, 2, 5, 0};
    int ptab  [4] = '{2, 3, 3, 0};
    int m_credit = 0, m_phase = 0, m_price = 0, m_dsel = 0, m_add = 0, m_t0 = 0, cyc = 0;
    bit m_dreq = 0, m_creq = 0, m_ccoin = 0, m_rej = 0, m_err = 0, m_fault = 0, m_busy = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_credit = 0; m_phase = 0; m_dsel = 0; m_creq = 0; m_ccoin = 0;
            m_rej = 0; m_err = 0; m_fault = 0; m_dreq = 0; m_busy = 0;
        end else begin
            cyc++;
            m_rej = 0; m_err = 0; m_fault = 0; m_add = 0;
            if (coin_valid) begin
                if (m_phase == 0 && units[coin_val] != 0 && m_credit + units[coin_val] <= 63)
                    m_add = units[coin_val];
                else
                    m_rej = 1;
            end
            if (m_phase == 0) begin
                if (cancel) begin
                    if (m_credit > 0) m_phase = 2;
                end else if (sel_valid) begin
                    if (ptab[sel] != 0 && m_credit >= ptab[sel]) begin
                        m_phase = 1; m_dsel = sel; m_price = ptab[sel]; m_t0 = cyc;
                    end else m_err = 1;
                end
            end else if (m_phase == 1) begin
                if (disp_ack) begin
                    m_credit -= m_price;
                    m_phase = m_credit > 0 ? 2 : 0;
                end
`ifdef VEND_TIMEOUT_EN
                else if (cyc - m_t0 == TO) begin
                    m_fault = 1; m_phase = 2;
                end
`endif
            end else if (m_creq && chg_ack) begin
                m_credit -= m_ccoin ? 2 : 1;
                m_creq = 0;
                if (m_credit == 0) m_phase = 0;
            end else m_creq = 1;
            m_credit += m_add;
            m_dreq  = m_phase == 1;
            m_busy  = m_phase != 0;
            m_ccoin = m_phase == 2 && m_credit >= 2;
        end
    end

    always @(negedge clk) begin
        chk("m_credit", int'(credit), m_credit);
        chk("m_busy", int'(busy), int'(m_busy));
        chk("m_disp_req", int'(disp_req), int'(m_dreq));
        chk("m_chg_req", int'(chg_req), int'(m_creq));
        chk("m_coin_rej", int'(coin_rej), int'(m_rej));
        chk("m_err_price", int'(err_price), int'(m_err));
        chk("m_fault", int'(fault), int'(m_fault));
        if (m_dreq) chk("m_disp_sel", int'(disp_sel), m_dsel);
        if (m_creq) chk("m_chg_coin", int'(chg_coin), int'(m_ccoin));
    end

    bit coins [$];

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1; coin_val = v;
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] s);
        sel_valid = 1'b1; sel = s;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic dack();
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
    endtask

    task automatic cack();
        chg_ack = 1'b1;
        @(negedge clk);
        chg_ack = 1'b0;
    endtask

    task automatic serve_change(input int budget);
        int k = 0;
        coins.delete();
        while (busy && k < budget) begin
            if (chg_req) begin
                coins.push_back(chg_coin);
                chg_ack = 1'b1;
            end else chg_ack = 1'b0;
            @(negedge clk);
            k++;
        end
        chg_ack = 1'b0;
        chk("change_done", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_disp_req", int'(disp_req), 0);
        chk("rst_chg_req", int'(chg_req), 0);
        reset_n = 1'b1;
        @(negedge clk);

        coin(2'd1); chk("t1_credit_a", int'(credit), 2);
        coin(2'd1); chk("t1_credit_b", int'(credit), 4);
        coin(2'd0); chk("t1_credit_c", int'(credit), 5);
        select(2'd2);
        chk("t1_disp_req", int'(disp_req), 1);
        chk("t1_disp_sel", int'(disp_sel), 2);
        repeat (3) @(negedge clk);
        chk("t1_disp_hold", int'(disp_req), 1);
        dack();
        chk("t1_disp_fall", int'(disp_req), 0);
        chk("t1_credit_after", int'(credit), 2);
        chk("t1_chg_not_yet", int'(chg_req), 0);
        @(negedge clk);
        chk("t1_chg_req", int'(chg_req), 1);
        chk("t1_chg_coin", int'(chg_coin), 1);
        cack();
        chk("t1_chg_fall", int'(chg_req), 0);
        chk("t1_credit_zero", int'(credit), 0);
        chk("t1_idle", int'(busy), 0);

        dack(); cack();
        chk("stray_ack_credit", int'(credit), 0);
        chk("stray_ack_busy", int'(busy), 0);

        coin(2'd0);
        select(2'd0);
        chk("t2_err", int'(err_price), 1);
        chk("t2_no_disp", int'(disp_req), 0);
        chk("t2_credit", int'(credit), 1);
        @(negedge clk);
        chk("t2_err_pulse", int'(err_price), 0);
        select(2'd3);
        chk("t2_err_disabled", int'(err_price), 1);
        do_cancel();
        serve_change(50);
        chk("t2_refund_n", coins.size(), 1);
        if (coins.size() > 0) chk("t2_refund_coin", int'(coins[0]), 0);

        repeat (12) coin(2'd2);
        coin(2'd0);
        chk("t3_credit61", int'(credit), 61);
        coin(2'd2);
        chk("t3_ovf_rej", int'(coin_rej), 1);
        chk("t3_ovf_credit", int'(credit), 61);
        coin(2'd3);
        chk("t3_inv_rej", int'(coin_rej), 1);
        coin(2'd1);
        chk("t3_credit63", int'(credit), 63);
        chk("t3_accept", int'(coin_rej), 0);
        do_cancel();
        serve_change(400);
        chk("t3_refund_n", coins.size(), 32);
        chk("t3_credit0", int'(credit), 0);

        coin(2'd1); coin(2'd0);
        chk("t4_credit3", int'(credit), 3);
        cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0;
        @(negedge clk);
        cancel = 1'b0; sel_valid = 1'b0;
        chk("t4_no_disp", int'(disp_req), 0);
        chk("t4_no_err", int'(err_price), 0);
        chk("t4_busy", int'(busy), 1);
        serve_change(50);
        chk("t4_refund_n", coins.size(), 2);
        if (coins.size() > 1) begin
            chk("t4_coin0", int'(coins[0]), 1);
            chk("t4_coin1", int'(coins[1]), 0);
        end

        coin(2'd2);
        select(2'd1);
        chk("t5_disp_req", int'(disp_req), 1);
        coin(2'd1);
        chk("t5_busy_rej", int'(coin_rej), 1);
        chk("t5_credit", int'(credit), 5);
        dack();
        chk("t5_credit_after", int'(credit), 2);
        @(negedge clk);
        chk("t5_chg_req", int'(chg_req), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("t5_rst_chg_req", int'(chg_req), 0);
        chk("t5_rst_credit", int'(credit), 0);
        chk("t5_rst_busy", int'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef VEND_TIMEOUT_EN
        begin
            int k = 1;
            coin(2'd2);
            select(2'd1);
            while (!fault && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk("t6_fault_cycle", k, 256);
            chk("t6_credit_kept", int'(credit), 5);
            chk("t6_disp_drop", int'(disp_req), 0);
            serve_change(100);
            chk("t6_refund_n", coins.size(), 3);
            if (coins.size() > 2) begin
                chk("t6_coin0", int'(coins[0]), 1);
                chk("t6_coin1", int'(coins[1]), 1);
                chk("t6_coin2", int'(coins[2]), 0);
            end
            coin(2'd2);
            select(2'd1);
            repeat (254) @(negedge clk);
            chk("t6_still_req", int'(disp_req), 1);
            dack();
            chk("t6_ack_no_fault", int'(fault), 0);
            chk("t6_ack_credit", int'(credit), 2);
            serve_change(100);
            chk("t6_ack_refund_n", coins.size(), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vend_dispense_sequencer.md
# vend_dispense_sequencer

Transaction controller for the coin-operated vending datapath: accumulates inserted-coin credit, checks a product selection against a per-product price table, sequences the dispense mechanism over a req/ack handshake, then returns change one coin at a time over a second req/ack handshake. It sits between the coin acceptor front end and the dispense/change actuators. It replaces ad-hoc per-coin decoding with one credit register and one FSM.

## Interface
- CREDIT_W, 6, credit width in 5-cent units (max credit 2^CREDIT_W-1)
- NUM_SEL, 4, number of products (sel width = 2, fixed for NUM_SEL ≤ 4)
- PRICES, {6'd5,6'd4,6'd3,6'd2}, packed NUM_SEL×CREDIT_W price table in 5-cent units, product 0 in LSBs; price 0 = product disabled
- TIMEOUT, 255, dispense-ack timeout in cycles (used only with VEND_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle pulse, coin inserted
- coin_val  in  2  00=5c (1 unit), 01=10c (2), 10=25c (5), 11=invalid
- coin_rej  out  1  one-cycle pulse, coin returned unaccepted
- sel_valid  in  1  one-cycle pulse, product selected
- sel  in  2  product index
- cancel  in  1  one-cycle pulse, refund request
- disp_req  out  1  dispense request, held until disp_ack
- disp_sel  out  2  product being dispensed, stable while disp_req
- disp_ack  in  1  dispense done
- chg_req  out  1  change-coin request, held until chg_ack
- chg_coin  out  1  0=5c, 1=10c, stable while chg_req
- chg_ack  in  1  change coin ejected
- credit  out  CREDIT_W  current credit, units of 5c
- busy  out  1  high in any state except IDLE
- err_price  out  1  one-cycle pulse, selection refused
- fault  out  1  one-cycle pulse, dispense timeout (VEND_TIMEOUT_EN only; else tied 0)

## Operation
- FSM states: IDLE, DISPENSE, CHANGE.
- IDLE: coin_valid with valid coin_val and credit+value ≤ max → credit += value. Invalid code or overflow → coin_rej, credit unchanged.
- Coins in DISPENSE/CHANGE always rejected (coin_rej).
- IDLE, sel_valid: price = PRICES[sel]. If price ≠ 0, sel < NUM_SEL and credit ≥ price → DISPENSE with disp_sel = sel. Otherwise → err_price, stay IDLE.
- Selection and cancel compare against registered credit (value before any same-cycle coin). A same-cycle coin is still accepted.
- IDLE, cancel with credit > 0 → CHANGE. Cancel with credit 0 → no effect.
- cancel and sel_valid in the same cycle: cancel wins, selection is dropped without err_price.
- DISPENSE: disp_req = 1. On disp_ack: credit -= price, disp_req falls, then go to CHANGE if the remaining credit > 0, else IDLE. cancel and sel are ignored.
- CHANGE: chg_req = 1, chg_coin = 1 if credit ≥ 2 else 0. On chg_ack: credit -= 2 or 1. Exit to IDLE when credit reaches 0.
- Acks received while the matching req is low are ignored.
- Reset mid-transaction: everything is cleared immediately and credit is lost. This is intentional; the mechanical escrow handles refunds.

## Timing
- Reset values: state IDLE; credit 0; all req and pulse outputs 0; disp_sel 0; chg_coin 0; busy 0.
- All outputs are registered.
- Credit updates the cycle after coin_valid. coin_rej and err_price appear 1 cycle after their cause.
- disp_req rises 1 cycle after sel_valid and falls 1 cycle after disp_ack. Credit is decremented on the same edge.
- chg_req rises on the cycle after entering CHANGE. After each chg_ack it drops for exactly 1 cycle, then re-asserts if credit remains. chg_coin is updated during that low cycle.
- A transaction with no change returns to IDLE 1 cycle after disp_ack.

## Configuration
- VEND_TIMEOUT_EN defined:
  - An 8+-bit counter runs while in DISPENSE.
  - If TIMEOUT cycles pass without disp_ack: disp_req drops, fault pulses, credit is kept (no price deducted), and the FSM goes to CHANGE for a full refund.
  - A disp_ack arriving in the same cycle as the timeout wins.
- VEND_TIMEOUT_EN undefined: DISPENSE waits indefinitely; fault is constant 0; no counter is synthesized.

## Test plan
- Coins 10c, 10c, 5c → credit 2, 4, 5. Then sel=2 (price 3) → disp_req with disp_sel=2. Ack → credit 2, one chg_req with chg_coin=1, ack → IDLE, credit 0.
- credit 1, sel=0 (price 2) → err_price one cycle, no disp_req, credit stays 1. Repeat with sel=3 and PRICES[3]=0 → err_price.
- credit 61 (max 63), insert 25c → coin_rej, credit 61. Insert coin_val=11 → coin_rej. Insert 10c → credit 63.
- credit 3, cancel and sel_valid in the same cycle → no dispense, change sequence 10c then 5c, credit 0.
- Coin inserted during DISPENSE → coin_rej, credit unchanged. Assert reset_n low mid-CHANGE → chg_req 0 and credit 0 immediately.
- With VEND_TIMEOUT_EN and TIMEOUT=255, credit 5, sel=1, no ack → fault on cycle 256 after disp_req rises, refund 10c+10c+5c. Repeat with disp_ack on cycle 255 → normal dispense.
